// File: rtl/bnn_isa_pkg.sv
// rtl/bnn_isa_pkg.sv - BNN sequencer ISA opcodes, register indices and core_ctrl field map
package bnn_isa_pkg;

   localparam int CORE_W_DEF = 17;

   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_LDL   = 5'd1;
   localparam logic [4:0] OP_LDH   = 5'd2;
   localparam logic [4:0] OP_LOAD  = 5'd3;
   localparam logic [4:0] OP_ADDI  = 5'd4;
   localparam logic [4:0] OP_CMP   = 5'd5;
   localparam logic [4:0] OP_JMP   = 5'd6;
   localparam logic [4:0] OP_EMPT  = 5'd7;
   localparam logic [4:0] OP_BPUE  = 5'd8;
   localparam logic [4:0] OP_BPUC  = 5'd9;
   localparam logic [4:0] OP_OUT   = 5'd10;
   localparam logic [4:0] OP_STORE = 5'd11;
   localparam logic [4:0] OP_SHIFT = 5'd12;
   localparam logic [4:0] OP_MOVE  = 5'd13;
   localparam logic [4:0] OP_HALT  = 5'd31;

   localparam logic [2:0] RI_PC  = 3'd0;
   localparam logic [2:0] RI_LD  = 3'd1;
   localparam logic [2:0] RI_AUX = 3'd2;
   localparam logic [2:0] RI_ST  = 3'd3;
   localparam logic [2:0] RI_R1  = 3'd4;
   localparam logic [2:0] RI_R2  = 3'd5;
   localparam logic [2:0] RI_R3  = 3'd6;
   localparam logic [2:0] RI_R4  = 3'd7;

   // core_ctrl bit positions; pulse ops also carry inst[4:0] in the arg field
   localparam int CC_LOAD  = 0;
   localparam int CC_LTYPE = 1;
   localparam int CC_COL   = 3;
   localparam int CC_HALF  = 5;
   localparam int CC_EMPT  = 6;
   localparam int CC_BPUE  = 7;
   localparam int CC_BPUC  = 8;
   localparam int CC_OUT   = 9;
   localparam int CC_SHIFT = 10;
   localparam int CC_STORE = 11;
   localparam int CC_ARG   = 12;
   localparam int CC_ARG_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/bnn_seq_regfile.sv
// rtl/bnn_seq_regfile.sv - 8-entry register file, index 0 reads the executing pc
module bnn_seq_regfile
   import bnn_isa_pkg::*;
#(
   parameter int REG_W = 16,
   parameter int PC_W  = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PC_W-1:0]  pc,
   input  logic [2:0]       ra_addr,
   output logic [REG_W-1:0] ra_data,
   input  logic [2:0]       rb_addr,
   output logic [REG_W-1:0] rb_data,
   input  logic             we,
   input  logic [2:0]       wa,
   input  logic [REG_W-1:0] wd,
   input  logic             ld_step,
   input  logic             ld_down,
   input  logic             st_step,
   input  logic             st_down,
   output logic [REG_W-1:0] ld_ptr,
   output logic [REG_W-1:0] st_ptr
);

   logic [REG_W-1:0] regs [0:7];
   logic [REG_W-1:0] pc_ext;

   assign pc_ext  = REG_W'(pc);
   assign ra_data = (ra_addr == RI_PC) ? pc_ext : regs[ra_addr];
   assign rb_data = (rb_addr == RI_PC) ? pc_ext : regs[rb_addr];
   assign ld_ptr  = regs[RI_LD];
   assign st_ptr  = regs[RI_ST];

   // entry 0 is never written; its slot only exists to keep indexing uniform
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         if (we && wa != RI_PC) regs[wa] <= wd;
         if (ld_step) regs[RI_LD] <= ld_down ? regs[RI_LD] - REG_W'(1) : regs[RI_LD] + REG_W'(1);
         if (st_step) regs[RI_ST] <= st_down ? regs[RI_ST] - REG_W'(1) : regs[RI_ST] + REG_W'(1);
      end
   end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// rtl/bnn_seq_ctrl.sv - BNN instruction sequencer: fetch pipeline, decode, pause replay
module bnn_seq_ctrl
   import bnn_isa_pkg::*;
#(
   parameter int IADDR_W = 11,
   parameter int DADDR_W = 13,
   parameter int REG_W   = 16,
   parameter int CORE_W  = CORE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic [15:0]        inst,
   output logic [IADDR_W-1:0] iaddr,
   output logic               icen,
   output logic [CORE_W-1:0]  core_ctrl,
   output logic [DADDR_W-1:0] daddr,
   output logic               dcen,
   output logic               dwen,
   output logic               busy,
   output logic               done
);

   seq_state_t         state;
   logic [IADDR_W-1:0] ex_pc;
   logic               ex_vld;

   logic [4:0]         op;
   logic               exec;
   logic [2:0]         rb_addr;
   logic [REG_W-1:0]   ra_data, rb_data, wd, ld_ptr, st_ptr;
   logic [2:0]         wa;
   logic               we, ld_step, ld_down, st_step, st_down, take, halt;
   logic [IADDR_W-1:0] jmp_target, replay_pc;
   logic [CORE_W-1:0]  cc_nxt;
   logic [DADDR_W-1:0] daddr_nxt;
   logic               dcen_nxt, dwen_nxt;

   assign op         = inst[15:11];
   assign exec       = (state == ST_RUN) && ex_vld && !pause;
   assign rb_addr    = (op == OP_JMP) ? RI_R1 : inst[7:5];
   assign jmp_target = ex_pc - IADDR_W'(inst[10:0]);
   // a squash bubble has no valid ex_pc; the pending word is then the one at iaddr
   assign replay_pc  = ex_vld ? ex_pc : iaddr;

   assign icen = (state != ST_RUN);
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   bnn_seq_regfile #(.REG_W(REG_W), .PC_W(IADDR_W)) u_rf (
      .clk     (clk),
      .rst     (rst),
      .pc      (ex_pc),
      .ra_addr (inst[10:8]),
      .ra_data (ra_data),
      .rb_addr (rb_addr),
      .rb_data (rb_data),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .ld_step (ld_step),
      .ld_down (ld_down),
      .st_step (st_step),
      .st_down (st_down),
      .ld_ptr  (ld_ptr),
      .st_ptr  (st_ptr)
   );

   always_comb begin
      we        = 1'b0;
      wa        = inst[10:8];
      wd        = ra_data;
      ld_step   = 1'b0;
      ld_down   = 1'b0;
      st_step   = 1'b0;
      st_down   = 1'b0;
      take      = 1'b0;
      halt      = 1'b0;
      cc_nxt    = '0;
      daddr_nxt = daddr;
      dcen_nxt  = 1'b1;
      dwen_nxt  = 1'b1;
      if (exec) begin
         case (op)
            OP_LDL: begin
               we      = 1'b1;
               wd[7:0] = inst[7:0];
            end
            OP_LDH: begin
               we       = 1'b1;
               wd[15:8] = inst[7:0];
            end
            OP_LOAD: begin
               ld_step                = 1'b1;
               ld_down                = !inst[0];
               daddr_nxt              = DADDR_W'(ld_ptr);
               dcen_nxt               = 1'b0;
               cc_nxt[CC_LOAD]        = 1'b1;
               cc_nxt[CC_LTYPE +: 2]  = inst[10:9];
               cc_nxt[CC_COL +: 2]    = inst[8:7];
               cc_nxt[CC_HALF]        = inst[6];
            end
            OP_ADDI: begin
               we = 1'b1;
               wd = ra_data + {{(REG_W-8){inst[7]}}, inst[7:0]};
            end
            OP_CMP: begin
               we = 1'b1;
               wa = RI_R1;
               wd = REG_W'(ra_data < REG_W'(inst[7:0]));
            end
            OP_JMP:  take = (rb_data != '0);
            OP_STORE: begin
               st_step          = 1'b1;
               st_down          = inst[10];
               daddr_nxt        = DADDR_W'(st_ptr);
               dcen_nxt         = 1'b0;
               dwen_nxt         = 1'b0;
               cc_nxt[CC_STORE] = 1'b1;
            end
            OP_MOVE: begin
               we = 1'b1;
               wd = rb_data;
            end
            OP_EMPT, OP_BPUE, OP_BPUC, OP_OUT, OP_SHIFT: begin
               cc_nxt[CC_ARG +: CC_ARG_W] = inst[4:0];
               case (op)
                  OP_EMPT: cc_nxt[CC_EMPT]  = 1'b1;
                  OP_BPUE: cc_nxt[CC_BPUE]  = 1'b1;
                  OP_BPUC: cc_nxt[CC_BPUC]  = 1'b1;
                  OP_OUT:  cc_nxt[CC_OUT]   = 1'b1;
                  default: cc_nxt[CC_SHIFT] = 1'b1;
               endcase
            end
            OP_HALT: halt = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         iaddr     <= '0;
         ex_pc     <= '0;
         ex_vld    <= 1'b0;
         core_ctrl <= '0;
         daddr     <= '0;
         dcen      <= 1'b1;
         dwen      <= 1'b1;
      end else begin
         core_ctrl <= cc_nxt;
         daddr     <= daddr_nxt;
         dcen      <= dcen_nxt;
         dwen      <= dwen_nxt;
         case (state)
            ST_IDLE: begin
               ex_vld <= 1'b0;
               if (start) begin
                  state <= ST_RUN;
                  iaddr <= '0;
               end
            end
            ST_RUN: begin
               // pause outranks halt and jump so the stalled instruction replays intact
               if (pause) begin
                  iaddr  <= replay_pc;
                  ex_pc  <= replay_pc;
                  ex_vld <= 1'b0;
               end else if (halt) begin
                  state  <= ST_DONE;
                  ex_vld <= 1'b0;
               end else if (take) begin
                  iaddr  <= jmp_target;
                  ex_vld <= 1'b0;
               end else begin
                  ex_pc  <= iaddr;
                  ex_vld <= 1'b1;
                  iaddr  <= iaddr + IADDR_W'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb/tb_bnn_seq_ctrl.sv - directed self-checking bench for bnn_seq_ctrl
module tb_bnn_seq_ctrl;
   import bnn_isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, pause;
   logic [15:0] inst;
   logic [10:0] iaddr;
   logic        icen, dcen, dwen, busy, done;
   logic [16:0] core_ctrl;
   logic [12:0] daddr;

   logic [15:0] imem [0:2047];
   int n_chk = 0, n_pass = 0;
   int ld_cnt, wr_cnt, empt_cnt, busy_cyc, done_cnt;
   logic [12:0] ld_addr, wr_addr;
   logic [16:0] ld_cc;

   always #5 clk = ~clk;

   bnn_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .inst      (inst),
      .iaddr     (iaddr),
      .icen      (icen),
      .core_ctrl (core_ctrl),
      .daddr     (daddr),
      .dcen      (dcen),
      .dwen      (dwen),
      .busy      (busy),
      .done      (done)
   );

   always @(posedge clk) if (!icen) inst <= imem[iaddr];

   always @(posedge clk) begin
      if (rst) begin
         ld_cnt <= 0; wr_cnt <= 0; empt_cnt <= 0; busy_cyc <= 0; done_cnt <= 0;
         ld_addr <= '0; wr_addr <= '0; ld_cc <= '0;
      end else begin
         if (!dcen && dwen) begin
            ld_cnt <= ld_cnt + 1; ld_addr <= daddr; ld_cc <= core_ctrl;
         end
         if (!dcen && !dwen) begin
            wr_cnt <= wr_cnt + 1; wr_addr <= daddr;
         end
         if (core_ctrl[CC_EMPT]) empt_cnt <= empt_cnt + 1;
         if (busy) busy_cyc <= busy_cyc + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] a, input logic [7:0] imm);
      return {op, a, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int max, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_inst(input logic [15:0] word, input int max, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (inst === word) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0;
      do_reset();
      @(negedge clk);
      check("rst_iaddr", 32'(iaddr), 32'd0);
      check("rst_icen", 32'(icen), 32'd1);
      check("rst_core_ctrl", 32'(core_ctrl), 32'd0);
      check("rst_daddr", 32'(daddr), 32'd0);
      check("rst_dcen_dwen", 32'({dcen, dwen}), 32'd3);
      check("rst_busy_done", 32'({busy, done}), 32'd0);

      // LDL/LDH build ld_ptr, LOAD weight col2 increments
      do_reset();
      imem[0] = enc(OP_LDL, 3'd1, 8'h05);
      imem[1] = enc(OP_LDH, 3'd1, 8'h01);
      imem[2] = 16'h1B01;
      imem[3] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      wait_done(40, "p1_done_seen");
      check("p1_load_count", 32'(ld_cnt), 32'd1);
      check("p1_load_daddr", 32'(ld_addr), 32'h105);
      check("p1_load_ctrl", 32'(ld_cc), 32'h13);
      check("p1_ld_ptr", 32'(dut.u_rf.regs[1]), 32'h106);
      check("p1_done_once", 32'(done_cnt), 32'd1);
      check("p1_idle", 32'({busy, icen}), 32'd1);

      // counted loop, body 3 times; start during RUN must be ignored
      do_reset();
      imem[0] = enc(OP_LDL, 3'd5, 8'h00);
      imem[1] = enc(OP_EMPT, 3'd0, 8'h00);
      imem[2] = enc(OP_ADDI, 3'd5, 8'h01);
      imem[3] = enc(OP_CMP, 3'd5, 8'h03);
      imem[4] = enc(OP_JMP, 3'd0, 8'h03);
      imem[5] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(60, "p2_done_seen");
      check("p2_body_count", 32'(empt_cnt), 32'd3);
      check("p2_r2", 32'(dut.u_rf.regs[5]), 32'd3);
      check("p2_r1", 32'(dut.u_rf.regs[4]), 32'd0);
      check("p2_run_cycles", 32'(busy_cyc), 32'd17);

      // STORE decrementing from st_ptr=0
      do_reset();
      imem[0] = enc(OP_STORE, 3'd4, 8'h00);
      imem[1] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      wait_done(30, "p3_done_seen");
      check("p3_write_count", 32'(wr_cnt), 32'd1);
      check("p3_write_daddr", 32'(wr_addr), 32'd0);
      check("p3_st_ptr", 32'(dut.u_rf.regs[3]), 32'hFFFF);

      // pause held 3 cycles on a STORE
      do_reset();
      imem[0] = enc(OP_LDL, 3'd3, 8'h20);
      imem[1] = enc(OP_STORE, 3'd0, 8'h00);
      imem[2] = enc(OP_NOP, 3'd0, 8'h00);
      imem[3] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      wait_inst(16'h5800, 20, "p4_store_seen");
      pause = 1'b1;
      repeat (3) @(negedge clk);
      check("p4_no_write_in_pause", 32'(wr_cnt), 32'd0);
      check("p4_dcen_in_pause", 32'(dcen), 32'd1);
      pause = 1'b0;
      wait_done(30, "p4_done_seen");
      check("p4_write_count", 32'(wr_cnt), 32'd1);
      check("p4_write_daddr", 32'(wr_addr), 32'h20);
      check("p4_st_ptr", 32'(dut.u_rf.regs[3]), 32'h21);

      // pause coincident with a taken JMP
      do_reset();
      imem[0] = enc(OP_LDL, 3'd4, 8'h02);
      imem[1] = enc(OP_EMPT, 3'd0, 8'h00);
      imem[2] = enc(OP_ADDI, 3'd4, 8'hFF);
      imem[3] = enc(OP_JMP, 3'd0, 8'h02);
      imem[4] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      wait_inst(16'h3002, 20, "p5_jmp_seen");
      pause = 1'b1;
      repeat (2) @(negedge clk);
      pause = 1'b0;
      wait_done(40, "p5_done_seen");
      check("p5_body_count", 32'(empt_cnt), 32'd2);
      check("p5_r1", 32'(dut.u_rf.regs[4]), 32'd0);
      check("p5_run_cycles", 32'(busy_cyc), 32'd13);

      // MOVE from index 0 at pc 0x12, LDL to index 0 ignored
      do_reset();
      imem[18] = enc(OP_MOVE, 3'd5, 8'h00);
      imem[19] = enc(OP_LDL, 3'd0, 8'h40);
      imem[20] = enc(OP_EMPT, 3'd0, 8'h00);
      imem[21] = enc(OP_HALT, 3'd0, 8'h00);
      pulse_start();
      wait_done(80, "p6_done_seen");
      check("p6_r2_pc", 32'(dut.u_rf.regs[5]), 32'h12);
      check("p6_empt_count", 32'(empt_cnt), 32'd1);
      check("p6_run_cycles", 32'(busy_cyc), 32'd23);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
